// File: rtl/traffic_phase_scheduler.sv
// Three-road junction phase sequencer: one road green at a time, green length from density.
// Optional emergency preemption is compiled in when EMERGENCY_PREEMPT_EN is defined.
module traffic_phase_scheduler #(
  parameter int GREEN_LOW  = 5,
  parameter int GREEN_MED  = 10,
  parameter int GREEN_HIGH = 15,
  parameter int YELLOW_T   = 3,
  parameter int ALLRED_T   = 2,
  parameter int TW         = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    traffic_A,
  input  logic [1:0]    traffic_B,
  input  logic [1:0]    traffic_C,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic [2:0]    emerg,
`endif
  output logic          A_red,
  output logic          A_yellow,
  output logic          A_green,
  output logic          B_red,
  output logic          B_yellow,
  output logic          B_green,
  output logic          C_red,
  output logic          C_yellow,
  output logic          C_green,
  output logic [1:0]    state,
  output logic [1:0]    road,
  output logic [TW-1:0] timer,
  output logic          grant
);

  typedef enum logic [1:0] {
    ST_ALLRED = 2'b00,
    ST_GREEN  = 2'b01,
    ST_YELLOW = 2'b10
  } phase_t;

  phase_t        state_r, state_nx_s;
  logic [1:0]    road_r, road_nx_s;
  logic [1:0]    nxt_r, nxt_nx_s;
  logic [TW-1:0] timer_r, timer_nx_s;
  logic          grant_r, grant_nx_s;
  logic [8:0]    lamps_r;
  logic [1:0]    cand1_s, cand2_s, sel_s;
`ifdef EMERGENCY_PREEMPT_EN
  logic          hold_r, hold_nx_s;
  logic [1:0]    tgt_s;
`endif

  function automatic logic [1:0] road_inc(input logic [1:0] r);
    case (r)
      2'd0:    road_inc = 2'd1;
      2'd1:    road_inc = 2'd2;
      default: road_inc = 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] dens_of(input logic [1:0] r, input logic [1:0] a,
                                         input logic [1:0] b, input logic [1:0] c);
    case (r)
      2'd0:    dens_of = a;
      2'd1:    dens_of = b;
      default: dens_of = c;
    endcase
  endfunction

  // An empty road only gets a grant when everything is empty; it then runs the short green.
  function automatic logic [TW-1:0] green_load(input logic [1:0] d);
    case (d)
      2'b10:   green_load = TW'(GREEN_MED - 1);
      2'b11:   green_load = TW'(GREEN_HIGH - 1);
      default: green_load = TW'(GREEN_LOW - 1);
    endcase
  endfunction

  function automatic logic [2:0] lamp3(input phase_t ph, input logic [1:0] r, input logic [1:0] idx);
    if (r == idx && ph == ST_GREEN) begin
      lamp3 = 3'b001;
    end else if (r == idx && ph == ST_YELLOW) begin
      lamp3 = 3'b010;
    end else begin
      lamp3 = 3'b100;
    end
  endfunction

  assign cand1_s = road_inc(nxt_r);
  assign cand2_s = road_inc(cand1_s);
  assign sel_s   = (dens_of(nxt_r,   traffic_A, traffic_B, traffic_C) != 2'b00) ? nxt_r   :
                   (dens_of(cand1_s, traffic_A, traffic_B, traffic_C) != 2'b00) ? cand1_s :
                   (dens_of(cand2_s, traffic_A, traffic_B, traffic_C) != 2'b00) ? cand2_s : nxt_r;
`ifdef EMERGENCY_PREEMPT_EN
  assign tgt_s = emerg[0] ? 2'd0 : (emerg[1] ? 2'd1 : 2'd2);
`endif

  // Next-phase, timer, pointer and grant decisions.
  always_comb begin
    state_nx_s = state_r;
    road_nx_s  = road_r;
    nxt_nx_s   = nxt_r;
    timer_nx_s = timer_r - TW'(1);
    grant_nx_s = 1'b0;
    case (state_r)
      ST_ALLRED: begin
        if (timer_r == '0) begin
          state_nx_s = ST_GREEN;
          road_nx_s  = sel_s;
          timer_nx_s = green_load(dens_of(sel_s, traffic_A, traffic_B, traffic_C));
          grant_nx_s = 1'b1;
        end else begin
          state_nx_s = ST_ALLRED;
        end
      end
      ST_GREEN: begin
        if (timer_r != '0) begin
          state_nx_s = ST_GREEN;
        end else if (dens_of(road_inc(road_r), traffic_A, traffic_B, traffic_C) == 2'b00 &&
                     dens_of(road_inc(road_inc(road_r)), traffic_A, traffic_B, traffic_C) == 2'b00) begin
          timer_nx_s = TW'(GREEN_LOW - 1);
        end else begin
          state_nx_s = ST_YELLOW;
          timer_nx_s = TW'(YELLOW_T - 1);
        end
      end
      ST_YELLOW: begin
        if (timer_r == '0) begin
          state_nx_s = ST_ALLRED;
          timer_nx_s = TW'(ALLRED_T - 1);
          nxt_nx_s   = road_inc(road_r);
        end else begin
          state_nx_s = ST_YELLOW;
        end
      end
      default: begin
        state_nx_s = ST_ALLRED;
        road_nx_s  = 2'd0;
        timer_nx_s = TW'(ALLRED_T - 1);
      end
    endcase
`ifdef EMERGENCY_PREEMPT_EN
    hold_nx_s = 1'b0;
    if (emerg != 3'b000) begin
      if (state_r == ST_ALLRED && timer_r == '0) begin
        road_nx_s  = tgt_s;
        timer_nx_s = green_load(dens_of(tgt_s, traffic_A, traffic_B, traffic_C));
      end else if (state_r == ST_GREEN && road_r != tgt_s) begin
        state_nx_s = ST_YELLOW;
        timer_nx_s = TW'(YELLOW_T - 1);
      end else if (state_r == ST_GREEN) begin
        state_nx_s = ST_GREEN;
        timer_nx_s = timer_r;
        hold_nx_s  = 1'b1;
      end else begin
        hold_nx_s  = 1'b0;
      end
    end else if (state_r == ST_GREEN && hold_r) begin
      state_nx_s = ST_GREEN;
      timer_nx_s = TW'(GREEN_LOW - 1);
    end else begin
      hold_nx_s  = 1'b0;
    end
`endif
  end

  // State, status and lamp registers; lamps follow the next phase so they change with state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_ALLRED;
      road_r  <= 2'd0;
      nxt_r   <= 2'd0;
      timer_r <= TW'(ALLRED_T - 1);
      grant_r <= 1'b0;
      lamps_r <= 9'b100_100_100;
`ifdef EMERGENCY_PREEMPT_EN
      hold_r  <= 1'b0;
`endif
    end else begin
      state_r <= state_nx_s;
      road_r  <= road_nx_s;
      nxt_r   <= nxt_nx_s;
      timer_r <= timer_nx_s;
      grant_r <= grant_nx_s;
      lamps_r <= {lamp3(state_nx_s, road_nx_s, 2'd0),
                  lamp3(state_nx_s, road_nx_s, 2'd1),
                  lamp3(state_nx_s, road_nx_s, 2'd2)};
`ifdef EMERGENCY_PREEMPT_EN
      hold_r  <= hold_nx_s;
`endif
    end
  end

  assign {A_red, A_yellow, A_green, B_red, B_yellow, B_green, C_red, C_yellow, C_green} = lamps_r;
  assign state = state_r;
  assign road  = road_r;
  assign timer = timer_r;
  assign grant = grant_r;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed self-checking bench for traffic_phase_scheduler (default build).
module tb_traffic_phase_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] traffic_A = 2'b00, traffic_B = 2'b00, traffic_C = 2'b00;
  logic       A_red, A_yellow, A_green, B_red, B_yellow, B_green, C_red, C_yellow, C_green;
  logic [1:0] state, road;
  logic [4:0] timer;
  logic       grant;
  logic [8:0] lamps;

  int n_checks = 0;
  int n_errors = 0;

  traffic_phase_scheduler dut (
    .clk(clk), .reset(reset),
    .traffic_A(traffic_A), .traffic_B(traffic_B), .traffic_C(traffic_C),
    .A_red(A_red), .A_yellow(A_yellow), .A_green(A_green),
    .B_red(B_red), .B_yellow(B_yellow), .B_green(B_green),
    .C_red(C_red), .C_yellow(C_yellow), .C_green(C_green),
    .state(state), .road(road), .timer(timer), .grant(grant)
  );

  always #5 clk = ~clk;

  assign lamps = {A_red, A_yellow, A_green, B_red, B_yellow, B_green, C_red, C_yellow, C_green};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply reset with the given densities and release it just before edge 0.
  task automatic restart(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
    reset = 1'b0;
    traffic_A = a; traffic_B = b; traffic_C = c;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic lamps_legal(input logic [8:0] l);
    int nonred = 0;
    logic ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      logic [2:0] g;
      g = l[8-3*i -: 3];
      if (g != 3'b100 && g != 3'b010 && g != 3'b001) ok = 1'b0;
      if (g != 3'b100) nonred++;
    end
    if (nonred > 1) ok = 1'b0;
    return ok;
  endfunction

  initial begin
    int bad;
    int grants;

    // Reset values, A medium and others empty: A held green by extensions.
    restart(2'b10, 2'b00, 2'b00);
    check_eq("rst_state", state, 2'b00);
    check_eq("rst_timer", timer, 5'd1);
    check_eq("rst_lamps", lamps, 9'b100_100_100);
    check_eq("rst_grant", grant, 1'b0);
    tick();
    check_eq("t1_e0_state", state, 2'b00);
    check_eq("t1_e0_timer", timer, 5'd0);
    tick();
    check_eq("t1_e1_state", state, 2'b01);
    check_eq("t1_e1_road", road, 2'd0);
    check_eq("t1_e1_timer", timer, 5'd9);
    check_eq("t1_e1_grant", grant, 1'b1);
    check_eq("t1_e1_lamps", lamps, 9'b001_100_100);
    for (int e = 2; e <= 10; e++) tick();
    check_eq("t1_e10_timer", timer, 5'd0);
    tick();
    check_eq("t1_ext_state", state, 2'b01);
    check_eq("t1_ext_timer", timer, 5'd4);
    check_eq("t1_ext_grant", grant, 1'b0);
    bad = 0;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (lamps != 9'b001_100_100 || grant != 1'b0) bad++;
    end
    check_eq("t1_never_yellow", bad, 0);

    // Full rotation A=01, B=11, C=10.
    restart(2'b01, 2'b11, 2'b10);
    bad = 0;
    grants = 0;
    for (int e = 0; e <= 46; e++) begin
      tick();
      if (!lamps_legal(lamps)) bad++;
      if (e >= 1 && e <= 45 && grant) grants++;
      case (e)
        1:  begin check_eq("t2_a_g", {state, road, 3'b000, timer}, {2'b01, 2'd0, 3'b000, 5'd4});
                  check_eq("t2_a_grant", grant, 1'b1); end
        6:  check_eq("t2_a_y", {state, road, 3'b000, timer}, {2'b10, 2'd0, 3'b000, 5'd2});
        9:  begin check_eq("t2_a_ar", {state, road, 3'b000, timer}, {2'b00, 2'd0, 3'b000, 5'd1});
                  check_eq("t2_ar_lamps", lamps, 9'b100_100_100); end
        11: begin check_eq("t2_b_g", {state, road, 3'b000, timer}, {2'b01, 2'd1, 3'b000, 5'd14});
                  check_eq("t2_b_lamps", lamps, 9'b100_001_100); end
        26: begin check_eq("t2_b_y", {state, road, 3'b000, timer}, {2'b10, 2'd1, 3'b000, 5'd2});
                  check_eq("t2_by_lamps", lamps, 9'b100_010_100); end
        31: check_eq("t2_c_g", {state, road, 3'b000, timer}, {2'b01, 2'd2, 3'b000, 5'd9});
        41: check_eq("t2_c_y", {state, road, 3'b000, timer}, {2'b10, 2'd2, 3'b000, 5'd2});
        46: begin check_eq("t2_a_again", {state, road, 3'b000, timer}, {2'b01, 2'd0, 3'b000, 5'd4});
                  check_eq("t2_a_again_grant", grant, 1'b1); end
        default: ;
      endcase
    end
    check_eq("t2_grants", grants, 3);
    check_eq("t2_lamps_legal", bad, 0);

    // Empty A skipped: B granted directly, then reset while B green at timer 6.
    restart(2'b00, 2'b10, 2'b00);
    tick();
    tick();
    check_eq("t3_b_g", {state, road, 3'b000, timer}, {2'b01, 2'd1, 3'b000, 5'd9});
    for (int e = 2; e <= 4; e++) tick();
    check_eq("t3_b_t6", timer, 5'd6);
    #2;
    reset = 1'b0;
    #1;
    check_eq("t5_async_lamps", lamps, 9'b100_100_100);
    check_eq("t5_async_state", {state, road, 3'b000, timer}, {2'b00, 2'd0, 3'b000, 5'd1});
    traffic_A = 2'b01;
    @(negedge clk);
    reset = 1'b1;
    tick();
    tick();
    check_eq("t5_a_first", {state, road, 3'b000, timer}, {2'b01, 2'd0, 3'b000, 5'd4});

    // B alone with A and C empty: B extends, A never lit.
    restart(2'b00, 2'b10, 2'b00);
    bad = 0;
    for (int e = 0; e <= 11; e++) begin
      tick();
      if (lamps[8:6] != 3'b100) bad++;
    end
    check_eq("t3_b_ext", {state, road, 3'b000, timer}, {2'b01, 2'd1, 3'b000, 5'd4});
    check_eq("t3_a_red", bad, 0);

    // All empty: A gets GREEN_LOW and is extended every 5 cycles.
    restart(2'b00, 2'b00, 2'b00);
    tick();
    tick();
    check_eq("t4_a_low", {state, road, 3'b000, timer}, {2'b01, 2'd0, 3'b000, 5'd4});
    for (int e = 2; e <= 5; e++) tick();
    check_eq("t4_t0", timer, 5'd0);
    tick();
    check_eq("t4_ext1", {state, road, 3'b000, timer}, {2'b01, 2'd0, 3'b000, 5'd4});
    for (int e = 7; e <= 11; e++) tick();
    check_eq("t4_ext2", {state, road, 3'b000, timer}, {2'b01, 2'd0, 3'b000, 5'd4});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
